// File: rtl/hdmi_video_scheduler.sv
// Raster timing generator and TMDS period sequencer feeding three encoder channels.
// Define HDMI_VIDEO_PREAMBLE_EN to emit video preamble and guard band before each visible line.
module hdmi_video_scheduler #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] pix_in,
  output logic        pix_req,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic [7:0]  enc_data0,
  output logic [7:0]  enc_data1,
  output logic [7:0]  enc_data2,
  output logic [1:0]  enc_ctrl0,
  output logic [1:0]  enc_ctrl1,
  output logic [1:0]  enc_ctrl2,
  output logic        enc_active,
  output logic        guard
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

`ifdef HDMI_VIDEO_PREAMBLE_EN
  localparam logic [10:0] H_PRE_BEG  = 11'(H_TOTAL - 10);
  localparam logic [10:0] H_GRD_BEG  = 11'(H_TOTAL - 2);

  if (H_BP < 10) begin : g_hbp_check
    $error("H_BP must be at least 10 when the video preamble is enabled");
  end
`endif

  typedef enum logic [1:0] {P_CTRL, P_PRE, P_GUARD, P_VIDEO} period_t;

  // Control-symbol pair for channel 0 with sync polarity applied.
  function automatic logic [1:0] sync_lvl(input logic vs, input logic hs);
    return {vs ^ ~VSYNC_POL, hs ^ ~HSYNC_POL};
  endfunction

  logic [10:0] h_cnt_p0;
  logic [9:0]  v_cnt_p0;
  logic        vis_p0, hsync_p0, vsync_p0;
  period_t     state_nx, state_p1;
  logic        vld_p1, fs_p1, hsync_p1, vsync_p1;
  logic [10:0] x_p1;
  logic [9:0]  y_p1;
  logic        active_nx, guard_nx;
  logic [1:0]  ctrl0_nx, ctrl1_nx, ctrl2_nx;
  logic [23:0] data_nx;
  logic        vld_p2, guard_p2;
  logic [1:0]  ctrl0_p2, ctrl1_p2, ctrl2_p2;
  logic [23:0] data_p2;

  // p0: raster counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (h_cnt_p0 == H_LAST) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + 10'd1;
    end else begin
      h_cnt_p0 <= h_cnt_p0 + 11'd1;
    end
  end

  assign vis_p0   = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
  assign hsync_p0 = (h_cnt_p0 >= H_SYNC_BEG) && (h_cnt_p0 < H_SYNC_END);
  assign vsync_p0 = (v_cnt_p0 >= V_SYNC_BEG) && (v_cnt_p0 < V_SYNC_END);

`ifdef HDMI_VIDEO_PREAMBLE_EN
  logic [9:0] v_next_p0;
  assign v_next_p0 = (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + 10'd1;
`endif

  always_comb begin
    state_nx = P_CTRL;
    if (vis_p0) begin
      state_nx = P_VIDEO;
`ifdef HDMI_VIDEO_PREAMBLE_EN
    end else if ((v_next_p0 < V_ACT) && (h_cnt_p0 >= H_PRE_BEG)) begin
      state_nx = (h_cnt_p0 >= H_GRD_BEG) ? P_GUARD : P_PRE;
`endif
    end
  end

  // p1: pixel request, coordinates, period state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= P_CTRL;
      vld_p1   <= 1'b0;
      fs_p1    <= 1'b0;
      hsync_p1 <= 1'b0;
      vsync_p1 <= 1'b0;
      x_p1     <= '0;
      y_p1     <= '0;
    end else begin
      state_p1 <= state_nx;
      vld_p1   <= vis_p0;
      fs_p1    <= (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
      hsync_p1 <= hsync_p0;
      vsync_p1 <= vsync_p0;
      x_p1     <= vis_p0 ? h_cnt_p0 : '0;
      y_p1     <= vis_p0 ? v_cnt_p0 : '0;
    end
  end

  always_comb begin
    active_nx = 1'b0;
    guard_nx  = 1'b0;
    ctrl0_nx  = sync_lvl(vsync_p1, hsync_p1);
    ctrl1_nx  = 2'b00;
    ctrl2_nx  = 2'b00;
    data_nx   = '0;
    unique case (state_p1)
      P_VIDEO: begin
        active_nx = 1'b1;
        ctrl0_nx  = 2'b00;
        data_nx   = pix_in;
      end
`ifdef HDMI_VIDEO_PREAMBLE_EN
      P_PRE:   ctrl1_nx = 2'b01;
      P_GUARD: guard_nx = 1'b1;
`endif
      default: ;
    endcase
  end

  // p2: encoder-facing registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      guard_p2 <= 1'b0;
      ctrl0_p2 <= sync_lvl(1'b0, 1'b0);
      ctrl1_p2 <= 2'b00;
      ctrl2_p2 <= 2'b00;
      data_p2  <= '0;
    end else begin
      vld_p2   <= active_nx;
      guard_p2 <= guard_nx;
      ctrl0_p2 <= ctrl0_nx;
      ctrl1_p2 <= ctrl1_nx;
      ctrl2_p2 <= ctrl2_nx;
      data_p2  <= data_nx;
    end
  end

  assign pix_req     = vld_p1;
  assign x           = x_p1;
  assign y           = y_p1;
  assign frame_start = fs_p1;
  assign enc_active  = vld_p2;
  assign guard       = guard_p2;
  assign enc_ctrl0   = ctrl0_p2;
  assign enc_ctrl1   = ctrl1_p2;
  assign enc_ctrl2   = ctrl2_p2;
  assign enc_data2   = data_p2[23:16];
  assign enc_data1   = data_p2[15:8];
  assign enc_data0   = data_p2[7:0];

endmodule

// File: tb/tb_hdmi_video_scheduler.sv
// Scoreboard bench for hdmi_video_scheduler on a reduced raster; honours HDMI_VIDEO_PREAMBLE_EN.
module tb_hdmi_video_scheduler;

  localparam int HA = 8, HF = 2, HS = 3, HB = 10;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam bit HP = 1'b0, VP = 1'b0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
`ifdef HDMI_VIDEO_PREAMBLE_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pix_in = '0;
  logic        pix_req, frame_start, enc_active, guard;
  logic [10:0] x;
  logic [9:0]  y;
  logic [7:0]  enc_data0, enc_data1, enc_data2;
  logic [1:0]  enc_ctrl0, enc_ctrl1, enc_ctrl2;

  always #5 clk = ~clk;

  hdmi_video_scheduler #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in),
    .pix_req(pix_req), .x(x), .y(y), .frame_start(frame_start),
    .enc_data0(enc_data0), .enc_data1(enc_data1), .enc_data2(enc_data2),
    .enc_ctrl0(enc_ctrl0), .enc_ctrl1(enc_ctrl1), .enc_ctrl2(enc_ctrl2),
    .enc_active(enc_active), .guard(guard)
  );

  typedef struct {
    bit req; int x; int y; bit fs; bit hs; bit vs; int per;
  } s1_t;
  typedef struct {
    bit act; bit grd; logic [23:0] data; logic [1:0] c0; logic [1:0] c1; logic [1:0] c2;
  } s2_t;

  s1_t q1[$];
  s2_t q2[$];
  int checks = 0, failures = 0;
  int mh, mv, pix_cnt, fs_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // period codes: 0 ctrl, 1 preamble, 2 guard, 3 video
  function automatic s1_t model1(input int h, input int v);
    s1_t e;
    int nv;
    nv    = (v == VT - 1) ? 0 : v + 1;
    e.req = (h < HA) && (v < VA);
    e.x   = e.req ? h : 0;
    e.y   = e.req ? v : 0;
    e.fs  = (h == 0) && (v == 0);
    e.hs  = (h >= HA + HF) && (h < HA + HF + HS);
    e.vs  = (v >= VA + VF) && (v < VA + VF + VS);
    if (e.req) e.per = 3;
    else if (PRE && nv < VA && h >= HT - 10) e.per = (h >= HT - 2) ? 2 : 1;
    else e.per = 0;
    return e;
  endfunction

  function automatic s2_t model2(input s1_t e, input logic [23:0] pix);
    s2_t r;
    r.act  = (e.per == 3);
    r.grd  = (e.per == 2);
    r.data = (e.per == 3) ? pix : 24'h0;
    r.c0   = (e.per == 3) ? 2'b00 : {(e.vs ? VP : ~VP), (e.hs ? HP : ~HP)};
    r.c1   = (e.per == 1) ? 2'b01 : 2'b00;
    r.c2   = 2'b00;
    return r;
  endfunction

  function automatic s2_t reset2();
    s2_t r;
    r.act = 1'b0; r.grd = 1'b0; r.data = '0;
    r.c0 = {~VP, ~HP}; r.c1 = 2'b00; r.c2 = 2'b00;
    return r;
  endfunction

  task automatic advance();
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
  endtask

  task automatic check_enc(input string tag, input s2_t r);
    check_eq({tag, "_active"}, enc_active, r.act);
    check_eq({tag, "_guard"}, guard, r.grd);
    check_eq({tag, "_data"}, {enc_data2, enc_data1, enc_data0}, r.data);
    check_eq({tag, "_ctrl0"}, enc_ctrl0, r.c0);
    check_eq({tag, "_ctrl1"}, enc_ctrl1, r.c1);
    check_eq({tag, "_ctrl2"}, enc_ctrl2, r.c2);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req"}, pix_req, 0);
    check_eq({tag, "_xy"}, {x, y}, 0);
    check_eq({tag, "_fs"}, frame_start, 0);
    check_enc(tag, reset2());
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    q1.delete();
    q2.delete();
    mh = 0;
    mv = 0;
    q1.push_back(model1(0, 0));
    q2.push_back(reset2());
    advance();
  endtask

  task automatic step();
    s1_t e;
    s2_t r;
    logic [23:0] pix;
    @(posedge clk);
    #1;
    if (pix_req) pix_cnt++;
    if (frame_start) fs_cnt++;
    if (q1.size() == 0 || q2.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = q1.pop_front();
      check_eq("req", pix_req, e.req);
      check_eq("x", x, e.x);
      check_eq("y", y, e.y);
      check_eq("fs", frame_start, e.fs);
      r = q2.pop_front();
      check_enc("enc", r);
      pix = e.req ? {e.x[7:0], e.y[7:0], 8'hA5} : 24'($urandom);
      pix_in = pix;
      q2.push_back(model2(e, pix));
    end
    q1.push_back(model1(mh, mv));
    advance();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    release_reset();

    pix_cnt = 0;
    fs_cnt  = 0;
    repeat (FT) step();
    check_eq("pix_per_frame", pix_cnt, HA * VA);
    check_eq("fs_per_frame", fs_cnt, 1);

    for (int i = 0; i < 2 * FT && !(mh == 5 && mv == 2); i++) step();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset("midrst");
    repeat (2) @(posedge clk);
    #1;
    check_reset("midrst_hold");
    release_reset();

    pix_cnt = 0;
    fs_cnt  = 0;
    repeat (2 * FT) step();
    check_eq("pix_two_frames", pix_cnt, 2 * HA * VA);
    check_eq("fs_two_frames", fs_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdmi_video_scheduler.md
# hdmi_video_scheduler

Video timing generator and period sequencer that drives the three TMDS encoder channels. Produces raster counters, requests pixels from the frame source, and for every clock selects whether the encoders transmit pixel data or control symbols (sync, optional video preamble and guard band). Sits between the pixel source and the three encoder instances in the HDMI output path.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch clocks
- H_SYNC, 96, hsync width clocks
- H_BP, 48, horizontal back porch clocks (must be ≥ 10 when preamble compiled in)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, vsync width lines
- V_BP, 33, vertical back porch lines
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- pix_in  in  24  {R,G,B} from source, valid in the same cycle pix_req is high
- pix_req  out  1  pixel request for position (x,y)
- x  out  11  column of requested pixel
- y  out  10  row of requested pixel
- frame_start  out  1  one-cycle pulse with the request for (0,0)
- enc_data0/1/2  out  8  B / G / R to encoder channels 0/1/2
- enc_ctrl0/1/2  out  2  control symbols per channel
- enc_active  out  1  shared data-period flag to all encoders
- guard  out  1  downstream mux substitutes guard-band codes when high

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt 0..H_TOTAL-1, wraps and increments v_cnt; v_cnt wraps at V_TOTAL-1.
- Region order per axis: active, front porch, sync, back porch. hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync for v_cnt in the analogous range, whole lines.
- Visible when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Period FSM: CTRL → (PREAMBLE → GUARD, macro only) → VIDEO → CTRL.
  - VIDEO: visible. enc_active=1, enc_data = pix_in captured, enc_ctrl* = 00 (don't care to encoder).
  - CTRL: enc_active=0, guard=0, enc_ctrl0 = {vsync_lvl, hsync_lvl}, enc_ctrl1 = enc_ctrl2 = 00, enc_data* = 0.
  - PREAMBLE: h_cnt in [H_TOTAL-10, H_TOTAL-3] of a line whose successor line is visible (next v < V_ACTIVE, incl. v=V_TOTAL-1 → 0); enc_ctrl1=01, enc_ctrl2=00, ch0 carries sync.
  - GUARD: h_cnt in [H_TOTAL-2, H_TOTAL-1] of same lines; guard=1, enc_active=0.
- Sync levels are polarity-applied (hsync_lvl = hsync ^ ~HSYNC_POL).
- Reset mid-frame: counters to (0,0) next cycle, FSM to CTRL; first line after reset has no preamble/guard.

## Timing
- Cycle t: counters at (h,v). t+1: pix_req, x, y, frame_start registered. t+2: enc_* and guard registered; pix_in sampled at end of t+1.
- enc_active lags pix_req by exactly 1 cycle; sync/ctrl/guard outputs share that same 2-cycle pipeline so all encoder inputs stay aligned.
- pix_req high exactly H_ACTIVE consecutive cycles per visible line; x = h, y = v during it; x, y hold 0 otherwise.
- Reset values: pix_req, frame_start, enc_active, guard, enc_data*, enc_ctrl1/2 = 0; x=y=0; enc_ctrl0 = inactive sync levels ({~VSYNC_POL,~HSYNC_POL}).
- pix_in ignored when pix_req low; no back-pressure.

## Configuration
- HDMI_VIDEO_PREAMBLE_EN defined: PREAMBLE and GUARD states emitted as above; elaboration error if H_BP < 10.
- Undefined: pure DVI; FSM is CTRL/VIDEO only, guard tied 0, enc_ctrl1/2 always 00.

## Test plan
- Reset default params 1 frame: pix_req high 640 cycles × 480 lines, frame_start once per 420000 clocks, enc_active = pix_req delayed 1.
- Hsync: enc_ctrl0[0] = 0 exactly for h_cnt 656..751 (delayed 2), vsync enc_ctrl0[1] = 0 for lines 490–491.
- Macro on: before each visible line enc_ctrl1=01 for 8 clocks, then guard=1 for 2 clocks, then enc_active=1; no preamble before lines 480..523 successors.
- Macro off: guard never 1, enc_ctrl1/2 never non-zero across a full frame.
- Pixel path: pix_in = {x[7:0], y[7:0], 8'hA5} → enc_data2/1/0 match that pattern one cycle after each request.
- rst_n low mid-line (h=300, v=200): next cycle outputs at reset values; after release x/y restart at (0,0) with frame_start pulse.
